// File: rtl/kernel_config_loader.sv
// kernel_config_loader: fetches a kernel's coefficients from ROM into the shadow bank and commits them on a frame boundary
module kernel_config_loader #(
  parameter int SEL_W       = 3,
  parameter int COEF_W      = 8,
  parameter int TAPS        = 9,
  parameter int ROM_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [SEL_W-1:0]  i_kernel_sel,
  input  logic              i_frame_start,
  output logic [SEL_W+3:0]  o_rom_addr,
  input  logic [COEF_W-1:0] i_rom_data,
  output logic              o_coef_we,
  output logic [3:0]        o_coef_idx,
  output logic [COEF_W-1:0] o_coef_data,
  output logic              o_commit,
  output logic [SEL_W-1:0]  o_active_kernel,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT_COMMIT} state_t;
  localparam logic [3:0] LAST = 4'(TAPS - 1);
  state_t            state;
  logic [SEL_W-1:0]  target;
  logic [3:0]        tap;
  logic              issue;
  logic              init_pending;
  logic [ROM_LATENCY-1:0] vld;
  logic [3:0]        idx_pipe [ROM_LATENCY];
  logic              start;
  // a select change while waiting for the frame restarts the fetch unless the commit happens first
  assign start = (state == IDLE && (init_pending || i_kernel_sel != o_active_kernel)) ||
                 (state == WAIT_COMMIT && !i_frame_start && i_kernel_sel != target);
  assign o_coef_we   = vld[ROM_LATENCY-1];
  assign o_coef_idx  = idx_pipe[ROM_LATENCY-1];
  assign o_coef_data = o_coef_we ? i_rom_data : '0;
  assign o_busy      = state != IDLE;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      target          <= '0;
      tap             <= '0;
      issue           <= 1'b0;
      init_pending    <= 1'b1;
      o_rom_addr      <= '0;
      o_commit        <= 1'b0;
      o_active_kernel <= '0;
      vld             <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) idx_pipe[i] <= '0;
    end else begin
      o_commit    <= 1'b0;
      vld[0]      <= issue;
      idx_pipe[0] <= tap;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vld[i]      <= vld[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      if (start) begin
        state      <= FETCH;
        target     <= i_kernel_sel;
        tap        <= '0;
        issue      <= 1'b1;
        o_rom_addr <= {i_kernel_sel, 4'd0};
      end else if (state == FETCH) begin
        if (issue && tap == LAST) issue <= 1'b0;
        else if (issue) begin
          tap        <= tap + 4'd1;
          o_rom_addr <= {target, tap + 4'd1};
        end
        if (o_coef_we && o_coef_idx == LAST) state <= WAIT_COMMIT;
      end else if (state == WAIT_COMMIT && i_frame_start) begin
        state           <= IDLE;
        o_commit        <= 1'b1;
        o_active_kernel <= target;
        init_pending    <= 1'b0;
      end
    end
  end
endmodule
